serial_uart_endpoint: RTL and testbench
=======================================

Name: serial_uart_endpoint

Overview:
Device-side endpoint of the processor's byte-serial IO port. It faces the data_memory serial pins and bridges them to a physical 8N1 UART line. Bytes the processor writes are queued in a TX FIFO and shifted out on uart_tx_out. Bytes received on uart_rx_in are queued in an RX FIFO and presented to the processor with a valid flag.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; integer, minimum 4, even.
FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs; power of 2, minimum 2.

Ports:
clock  input  1  single system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
cpu_data_in  input  8  byte from processor (its serial_out).
cpu_wren_in  input  1  one-cycle push strobe (its serial_wren_out).
cpu_rden_in  input  1  one-cycle pop strobe (its serial_rden_out).
cpu_data_out  output  8  RX FIFO head byte (to its serial_in).
cpu_valid_out  output  1  RX FIFO non-empty (to its serial_valid_in).
cpu_ready_out  output  1  TX FIFO not full (to its serial_ready_in).
uart_rx_in  input  1  asynchronous serial line in, idle high.
uart_tx_out  output  1  serial line out, idle high.
rx_frame_err_out  output  1  sticky: a frame arrived with stop bit = 0.
rx_overrun_out  output  1  sticky: a good frame was dropped because the RX FIFO was full.

Behaviour:
- Reset (reset=0, takes effect immediately):
  - uart_tx_out=1, cpu_ready_out=1, cpu_valid_out=0, cpu_data_out=0x00.
  - Both sticky flags 0. FIFOs empty, both FSMs in IDLE, synchronizer flops = 1.
  - Asserting reset mid-frame aborts the frame; the line returns high at once.
- TX FIFO:
  - A push happens when cpu_wren_in=1 and the FIFO is not full. cpu_wren_in while full is silently dropped.
  - cpu_ready_out = !full, registered-state derived, with no combinational path from cpu_wren_in.
- RX FIFO:
  - Show-ahead: cpu_data_out is the head entry whenever cpu_valid_out=1, and 0x00 when empty.
  - A pop happens when cpu_rden_in=1 and the FIFO is non-empty. cpu_rden_in while empty is ignored.
- Both FIFOs accept a push and a pop in the same cycle; occupancy is unchanged. Pointers wrap modulo FIFO_DEPTH.
- TX FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: drive 0 for CLKS_PER_BIT cycles.
  - DATA: drive 8 bits LSB first, CLKS_PER_BIT cycles each.
  - STOP: drive 1 for CLKS_PER_BIT cycles, then return to IDLE.
- TX timing:
  - A byte pushed at edge N is popped at edge N+1 if the FSM is idle; uart_tx_out falls after edge N+1.
  - IDLE always lasts at least one cycle, so back-to-back frames repeat every 10*CLKS_PER_BIT+1 cycles.
- RX synchronization: uart_rx_in passes through a 2-flop synchronizer, and all RX decisions use the synchronized value.
- RX FSM states and transitions:
  - IDLE: a low level moves to START.
  - START: wait CLKS_PER_BIT/2 cycles and resample. If high, it was a glitch: return to IDLE with no flags. If low, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 times, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Stop=1 and FIFO not full: push the byte.
    - Stop=1 and FIFO full: drop the byte and set rx_overrun_out.
    - Stop=0: drop the byte and set rx_frame_err_out.
  - STOP then returns to IDLE. A framing-error frame returns to IDLE only after the line is seen high.
- RX push-to-visible latency: the byte appears on cpu_valid_out/cpu_data_out the cycle after the stop-bit sample edge.
- An RX push and a CPU pop in the same cycle are both honoured.
- Sticky flags clear only on reset.

Test Plan:
- Reset check: hold reset=0 for 3 cycles with uart_rx_in=1 -> uart_tx_out=1, cpu_ready_out=1, cpu_valid_out=0, cpu_data_out=0x00, both flags 0.
- Single TX, CLKS_PER_BIT=16: push 0x48 -> tx falls after the 2nd edge after the push. Bits 0,0,0,1,0,0,1,0 follow, 16 cycles each, then a stop bit 1; total frame 160 cycles.
- TX full: 6 back-to-back pushes 0x01..0x06 while idle -> cpu_ready_out=0 after the 5th push and 0x06 is dropped. Exactly 5 frames 0x01..0x05 go out, with start bits 161 cycles apart.
- Single RX: drive a 0xA5 frame on uart_rx_in -> cpu_valid_out=1, cpu_data_out=0xA5. Pulse cpu_rden_in -> cpu_valid_out=0 next cycle.
- RX errors:
  - A 4-cycle low glitch -> no byte, no flags.
  - A 0x3C frame with stop bit 0 -> no byte, rx_frame_err_out=1.
- Overrun/reset: send 5 frames 0x10..0x14 without reading -> 0x10..0x13 are popped in order and rx_overrun_out=1. Reset at cycle 50 of a TX frame -> uart_tx_out=1 immediately and the flags clear.

Source files
------------

// File: rtl/serial_uart_endpoint_if.sv
// Processor-facing byte-serial port of the UART endpoint.
// The master is the processor and the slave is the endpoint.
interface serial_uart_endpoint_if;
    logic [7:0] cpu_data_in;
    logic       cpu_wren_in;
    logic       cpu_rden_in;
    logic [7:0] cpu_data_out;
    logic       cpu_valid_out;
    logic       cpu_ready_out;

    modport master (
        output cpu_data_in,
        output cpu_wren_in,
        output cpu_rden_in,
        input  cpu_data_out,
        input  cpu_valid_out,
        input  cpu_ready_out
    );

    modport slave (
        input  cpu_data_in,
        input  cpu_wren_in,
        input  cpu_rden_in,
        output cpu_data_out,
        output cpu_valid_out,
        output cpu_ready_out
    );
endinterface

// File: rtl/serial_uart_endpoint.sv
// Bridges the processor serial port to an 8N1 UART line.
// TX and RX each have a show-ahead FIFO and a bit-timing FSM.
module serial_uart_endpoint #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    serial_uart_endpoint_if.slave bus,
    input  logic                  uart_rx_in,
    output logic                  uart_tx_out,
    output logic                  rx_frame_err_out,
    output logic                  rx_overrun_out
);

    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_BREAK = 3'd4;

    logic [7:0]       tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [PTR_W:0]   tx_count;
    logic             tx_full, tx_push, tx_pop;
    logic [1:0]       tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic             tx_bit_end;

    logic [7:0]       rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [PTR_W:0]   rx_count;
    logic             rx_full, rx_push, rx_pop, rx_nonempty;
    logic [1:0]       rx_sync;
    logic             rx_s;
    logic [2:0]       rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_stop_tick;

    assign tx_full    = (tx_count == DEPTH_C);
    assign tx_push    = bus.cpu_wren_in && !tx_full;
    assign tx_pop     = (tx_state == TX_IDLE) && (tx_count != '0);
    assign tx_bit_end = (tx_cnt == BIT_LAST);

    assign bus.cpu_ready_out = !tx_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= bus.cpu_data_in;
        if (tx_pop)
            tx_shift <= tx_mem[tx_rd_ptr];
        else if (tx_state == TX_DATA && tx_bit_end)
            tx_shift <= {1'b0, tx_shift[7:1]};
    end

    // The line is a registered output so it changes only on the bit-boundary edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            uart_tx_out <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= '0;
                    tx_bit <= '0;
                    if (tx_pop) begin
                        tx_state    <= TX_START;
                        uart_tx_out <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_cnt      <= '0;
                        tx_state    <= TX_DATA;
                        uart_tx_out <= tx_shift[0];
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state    <= TX_STOP;
                            uart_tx_out <= 1'b1;
                        end else begin
                            tx_bit      <= tx_bit + 1'b1;
                            uart_tx_out <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    uart_tx_out <= 1'b1;
                    if (tx_bit_end) begin
                        tx_cnt   <= '0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign rx_s         = rx_sync[1];
    assign rx_full      = (rx_count == DEPTH_C);
    assign rx_nonempty  = (rx_count != '0);
    assign rx_stop_tick = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST);
    assign rx_push      = rx_stop_tick && rx_s && !rx_full;
    assign rx_pop       = bus.cpu_rden_in && rx_nonempty;

    assign bus.cpu_valid_out = rx_nonempty;
    assign bus.cpu_data_out  = rx_nonempty ? rx_mem[rx_rd_ptr] : 8'h00;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_sync   <= 2'b11;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            rx_sync <= {rx_sync[0], uart_rx_in};
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_shift;
        if (rx_state == RX_DATA && rx_cnt == BIT_LAST)
            rx_shift <= {rx_s, rx_shift[7:1]};
    end

    // Start is confirmed at mid-bit, so every later sample lands mid-bit too.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state         <= RX_IDLE;
            rx_cnt           <= '0;
            rx_bit           <= '0;
            rx_frame_err_out <= 1'b0;
            rx_overrun_out   <= 1'b0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                    if (!rx_s) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_stop_tick) begin
                        rx_cnt <= '0;
                        if (!rx_s) begin
                            rx_frame_err_out <= 1'b1;
                            rx_state         <= RX_BREAK;
                        end else begin
                            if (rx_full) rx_overrun_out <= 1'b1;
                            rx_state <= RX_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    rx_cnt <= '0;
                    if (rx_s) rx_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_uart_endpoint.sv
// Directed bench for serial_uart_endpoint with CLKS_PER_BIT=16, FIFO_DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_uart_endpoint;
    logic clock;
    logic reset;
    logic uart_rx_in;
    logic uart_tx_out;
    logic rx_frame_err_out;
    logic rx_overrun_out;
    int   tests;
    int   fails;

    serial_uart_endpoint_if bus ();

    serial_uart_endpoint #(
        .CLKS_PER_BIT (16),
        .FIFO_DEPTH   (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .bus              (bus.slave),
        .uart_rx_in       (uart_rx_in),
        .uart_tx_out      (uart_tx_out),
        .rx_frame_err_out (rx_frame_err_out),
        .rx_overrun_out   (rx_overrun_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h, expected %02h", tag, obs, exp);
        end
    endtask

    // Called at offset 'off' (< 8) cycles into the start bit; returns 161 cycles after the start bit began.
    task automatic check_frame(input logic [7:0] b, input int off);
        logic exp;
        repeat (8 - off) @(negedge clock);
        for (int k = 0; k < 10; k++) begin
            exp = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            check_bit($sformatf("tx_%02h_bit%0d", b, k), uart_tx_out, exp);
            if (k < 9) repeat (16) @(negedge clock);
        end
        repeat (9) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rx_in = 1'b0;
        repeat (16) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx_in = b[i];
            repeat (16) @(negedge clock);
        end
        uart_rx_in = stop;
        repeat (16) @(negedge clock);
        uart_rx_in = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        uart_rx_in = 1'b1;
        bus.cpu_data_in = 8'h00;
        bus.cpu_wren_in = 1'b0;
        bus.cpu_rden_in = 1'b0;

        repeat (3) @(negedge clock);
        check_bit("rst_tx", uart_tx_out, 1'b1);
        check_bit("rst_ready", bus.cpu_ready_out, 1'b1);
        check_bit("rst_valid", bus.cpu_valid_out, 1'b0);
        check_byte("rst_data", bus.cpu_data_out, 8'h00);
        check_bit("rst_frame_err", rx_frame_err_out, 1'b0);
        check_bit("rst_overrun", rx_overrun_out, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // Single TX byte
        bus.cpu_data_in = 8'h48;
        bus.cpu_wren_in = 1'b1;
        @(negedge clock);
        bus.cpu_wren_in = 1'b0;
        check_bit("tx_latency_high", uart_tx_out, 1'b1);
        @(negedge clock);
        check_bit("tx_latency_low", uart_tx_out, 1'b0);
        check_frame(8'h48, 0);
        check_bit("tx_idle_after_48", uart_tx_out, 1'b1);

        // Six pushes into a four-entry FIFO while the transmitter drains one
        for (int k = 1; k <= 6; k++) begin
            bus.cpu_data_in = 8'(k);
            bus.cpu_wren_in = 1'b1;
            if (k == 5) check_bit("ready_before_full", bus.cpu_ready_out, 1'b1);
            if (k == 6) check_bit("ready_full", bus.cpu_ready_out, 1'b0);
            @(negedge clock);
        end
        bus.cpu_wren_in = 1'b0;
        check_bit("ready_still_full", bus.cpu_ready_out, 1'b0);
        check_frame(8'h01, 4);
        for (int k = 2; k <= 5; k++) begin
            check_bit($sformatf("start_spacing_%0d", k), uart_tx_out, 1'b0);
            check_frame(8'(k), 0);
        end
        check_bit("no_sixth_start", uart_tx_out, 1'b1);
        check_bit("ready_drained", bus.cpu_ready_out, 1'b1);
        repeat (200) @(negedge clock);
        check_bit("no_sixth_frame", uart_tx_out, 1'b1);

        // Single RX byte
        send_frame(8'hA5, 1'b1);
        repeat (2) @(negedge clock);
        check_bit("rx_a5_valid", bus.cpu_valid_out, 1'b1);
        check_byte("rx_a5_data", bus.cpu_data_out, 8'hA5);
        bus.cpu_rden_in = 1'b1;
        @(negedge clock);
        bus.cpu_rden_in = 1'b0;
        check_bit("rx_pop_valid", bus.cpu_valid_out, 1'b0);
        check_byte("rx_pop_data", bus.cpu_data_out, 8'h00);

        // Short glitch on the line
        uart_rx_in = 1'b0;
        repeat (4) @(negedge clock);
        uart_rx_in = 1'b1;
        repeat (40) @(negedge clock);
        check_bit("glitch_valid", bus.cpu_valid_out, 1'b0);
        check_bit("glitch_frame_err", rx_frame_err_out, 1'b0);
        check_bit("glitch_overrun", rx_overrun_out, 1'b0);

        // Frame with a bad stop bit
        send_frame(8'h3C, 1'b0);
        repeat (4) @(negedge clock);
        check_bit("ferr_valid", bus.cpu_valid_out, 1'b0);
        check_bit("ferr_flag", rx_frame_err_out, 1'b1);
        check_bit("ferr_overrun", rx_overrun_out, 1'b0);

        // Five frames into a four-entry RX FIFO
        for (int k = 0; k < 5; k++) begin
            send_frame(8'h10 + 8'(k), 1'b1);
            repeat (2) @(negedge clock);
        end
        check_bit("overrun_flag", rx_overrun_out, 1'b1);
        check_bit("overrun_ferr_sticky", rx_frame_err_out, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check_bit($sformatf("ovr_valid_%0d", k), bus.cpu_valid_out, 1'b1);
            check_byte($sformatf("ovr_data_%0d", k), bus.cpu_data_out, 8'h10 + 8'(k));
            bus.cpu_rden_in = 1'b1;
            @(negedge clock);
            bus.cpu_rden_in = 1'b0;
        end
        check_bit("ovr_empty", bus.cpu_valid_out, 1'b0);

        // Reset in the middle of a TX frame
        bus.cpu_data_in = 8'h00;
        bus.cpu_wren_in = 1'b1;
        @(negedge clock);
        bus.cpu_wren_in = 1'b0;
        @(negedge clock);
        repeat (50) @(negedge clock);
        check_bit("midframe_low", uart_tx_out, 1'b0);
        #1 reset = 1'b0;
        #1;
        check_bit("abort_tx_high", uart_tx_out, 1'b1);
        check_bit("abort_ferr_clr", rx_frame_err_out, 1'b0);
        check_bit("abort_ovr_clr", rx_overrun_out, 1'b0);
        check_bit("abort_ready", bus.cpu_ready_out, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        check_bit("after_abort_idle", uart_tx_out, 1'b1);
        check_bit("after_abort_valid", bus.cpu_valid_out, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
